// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the async Gray FIFO: pops words into a 2-entry skid buffer and presents them as a valid/ready stream.
// Optional occupancy output enabled by defining FIFO_RD_STREAM_LEVEL_EN.
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    input  logic             out_ready
`ifdef FIFO_RD_STREAM_LEVEL_EN
    ,
    input  logic [ASIZE:0]   w2r_wptr,
    input  logic [ASIZE:0]   rptr,
    output logic [ASIZE+1:0] rlevel
`endif
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_e;

    state_e           count_q, count_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] skid_q, skid_d;
    logic             push;
    logic             pop;

    // rinc looks only at registered state, so out_ready never reaches the read pointer.
    assign rinc      = ~rempty & (count_q != S2);
    assign push      = rinc;
    assign out_valid = (count_q != S0);
    assign pop       = out_valid & out_ready;
    assign out_data  = head_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (count_q)
            S0: begin
                if (push) begin
                    count_d = S1;
                    head_d  = rdata;
                end
            end
            S1: begin
                if (push && !pop) begin
                    count_d = S2;
                    skid_d  = rdata;
                end else if (!push && pop) begin
                    count_d = S0;
                end else if (push && pop) begin
                    head_d = rdata;
                end
            end
            S2: begin
                if (pop) begin
                    count_d = S1;
                    head_d  = skid_q;
                end
            end
            default: count_d = S0;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            count_q <= S0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

`ifdef FIFO_RD_STREAM_LEVEL_EN
    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ASIZE:0]   occ;
    logic [1:0]       count_bits;
    logic [ASIZE+1:0] rlevel_q, rlevel_d;

    // Modular pointer difference covers wrap; full FIFO reads as 2^ASIZE.
    assign occ        = gray2bin(w2r_wptr) - gray2bin(rptr);
    assign count_bits = count_q;
    assign rlevel_d   = {1'b0, occ} + {{ASIZE{1'b0}}, count_bits};
    assign rlevel     = rlevel_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rlevel_q <= '0;
        end else begin
            rlevel_q <= rlevel_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a small FIFO model feeds the DUT, a negedge monitor checks the stream.
module tb_fifo_rd_stream;
    localparam int DS = 8;
    localparam int AS = 4;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          rempty;
    logic [DS-1:0] rdata;
    logic          rinc;
    logic          out_valid;
    logic [DS-1:0] out_data;
    logic          out_ready = 1'b0;

    logic [DS-1:0] mem [0:255];
    logic [31:0]   wr_idx = 0;
    logic [31:0]   rd_idx = 0;
    logic          rempty_q = 1'b1;
    logic          rinc_s = 1'b0;
    logic [DS-1:0] exp_q[$];
    int            compared = 0;
    int            mismatched = 0;
    logic          stall_q = 1'b0;
    logic [DS-1:0] held = '0;

    assign rempty = rempty_q;
    assign rdata  = mem[rd_idx[7:0]];

`ifdef FIFO_RD_STREAM_LEVEL_EN
    logic [AS:0]   w2r_wptr;
    logic [AS:0]   rptr;
    logic [AS+1:0] rlevel;
    assign w2r_wptr = wr_idx[AS:0] ^ (wr_idx[AS:0] >> 1);
    assign rptr     = rd_idx[AS:0] ^ (rd_idx[AS:0] >> 1);
`endif

    fifo_rd_stream #(.DSIZE(DS), .ASIZE(AS)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef FIFO_RD_STREAM_LEVEL_EN
        ,
        .w2r_wptr  (w2r_wptr),
        .rptr      (rptr),
        .rlevel    (rlevel)
`endif
    );

    always #5 rclk = ~rclk;

    // FIFO model: registered empty flag that already accounts for a pop at the same edge.
    always @(negedge rclk) rinc_s <= rinc;

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_idx   <= wr_idx;
            rempty_q <= 1'b1;
        end else begin
            rd_idx   <= rd_idx + (rinc_s ? 32'd1 : 32'd0);
            rempty_q <= ((rd_idx + (rinc_s ? 32'd1 : 32'd0)) == wr_idx);
        end
    end

    // Monitor: order, loss, duplicates and stall stability.
    always @(negedge rclk) begin
        if (!rrst_n) begin
            exp_q.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                compared++;
                if (!out_valid || out_data !== held) begin
                    mismatched++;
                    $display("FAIL stall_hold: valid=%0b data=%0h required valid=1 data=%0h",
                             out_valid, out_data, held);
                end
            end
            if (out_valid && out_ready) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL stream_extra: data=%0h required no word", out_data);
                end else begin
                    logic [DS-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        mismatched++;
                        $display("FAIL stream_data: data=%0h required %0h", out_data, e);
                    end
                end
            end
            stall_q = out_valid && !out_ready;
            held    = out_data;
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic wr(input logic [DS-1:0] d);
        mem[wr_idx[7:0]] = d;
        wr_idx = wr_idx + 1;
        exp_q.push_back(d);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge rclk);
        while (!out_valid && n < 20) begin
            @(negedge rclk);
            n++;
        end
        chk(name, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd_base;
        int n;
        int cyc;

        // Reset state
        #22;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_rinc", {31'd0, rinc}, 32'd0);
`ifdef FIFO_RD_STREAM_LEVEL_EN
        chk("rst_level", {26'd0, rlevel}, 32'd0);
`endif
        tick();
        rrst_n = 1'b1;

        // Three words back to back with consumer ready
        tick();
        out_ready = 1'b1;
        wr(8'h11); wr(8'h22); wr(8'h33);
        wait_valid("t1_first_valid");
        @(negedge rclk); chk("t1_valid2", {31'd0, out_valid}, 32'd1);
        @(negedge rclk); chk("t1_valid3", {31'd0, out_valid}, 32'd1);
        @(negedge rclk);
        chk("t1_valid_end", {31'd0, out_valid}, 32'd0);
        chk("t1_rinc_end", {31'd0, rinc}, 32'd0);

        // Four words, consumer stalled: buffer takes exactly two
        tick();
        out_ready = 1'b0;
        rd_base = rd_idx;
        wr(8'h41); wr(8'h42); wr(8'h43); wr(8'h44);
        repeat (8) @(negedge rclk);
        chk("t2_pops", rd_idx - rd_base, 32'd2);
        chk("t2_rinc", {31'd0, rinc}, 32'd0);
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_head", {24'd0, out_data}, 32'h41);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge rclk);
            chk("t2_nogap", {31'd0, out_valid}, 32'd1);
        end
        @(negedge rclk);
        chk("t2_valid_end", {31'd0, out_valid}, 32'd0);

        // 1000 words with random backpressure
        n = 0;
        cyc = 0;
        while ((n < 1000 || exp_q.size() != 0) && cyc < 8000) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
            if (n < 1000 && (wr_idx - rd_idx) < 32'd16) begin
                wr(n[7:0]);
                n++;
            end
            cyc++;
        end
        out_ready = 1'b1;
        chk("t3_drained", exp_q.size(), 32'd0);
        chk("t3_written", n, 32'd1000);

        // Asynchronous reset with the buffer full
        tick();
        out_ready = 1'b0;
        wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
        repeat (6) @(negedge rclk);
        chk("t4_full_valid", {31'd0, out_valid}, 32'd1);
        chk("t4_full_rinc", {31'd0, rinc}, 32'd0);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("t4_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_rst_data", {24'd0, out_data}, 32'd0);
        chk("t4_rst_rinc", {31'd0, rinc}, 32'd0);
        repeat (2) @(negedge rclk);
        tick();
        rrst_n = 1'b1;

        // Empty FIFO for 10 cycles: nothing popped, nothing presented
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            chk("t5_rinc", {31'd0, rinc}, 32'd0);
            chk("t5_valid", {31'd0, out_valid}, 32'd0);
        end

`ifdef FIFO_RD_STREAM_LEVEL_EN
        // Occupancy: 16 words split between FIFO and buffer, then drain
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) wr(8'(8'hC0 + i));
        repeat (8) @(negedge rclk);
        chk("lvl_full", {26'd0, rlevel}, 32'd16);
        tick();
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(negedge rclk);
            cyc++;
        end
        chk("lvl_drained", exp_q.size(), 32'd0);
        repeat (3) @(negedge rclk);
        chk("lvl_empty", {26'd0, rlevel}, 32'd0);
`endif

        repeat (2) @(negedge rclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
